// File: rtl/priority_encoder_pkg.sv
// Shared types and segment constants for the priority encoder display path.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package priority_encoder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } convState_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [6:0] SEG_DIGIT [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

endpackage

// File: rtl/priority_encoder_7seg_bcd.sv
// Combinational BCD digit to active-low seven-segment decoder.
// Non-decimal nibbles decode to blank.
module bcd_to_7seg
    import priority_encoder_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (bcd <= 4'd9) seg = SEG_DIGIT[bcd];
    end

endmodule

// File: rtl/priority_encoder_7seg.sv
// Sampled priority encoder whose result is converted to BCD by a serial
// double-dabble engine and shown on a multiplexed seven-segment display.
module priority_encoder_7seg
    import priority_encoder_pkg::*;
#(
    parameter int N        = 16,
    parameter int W        = $clog2(N),
    parameter int DIGITS   = 2,
    parameter int SCAN_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req,
    input  logic              sample,
    output logic [W-1:0]      code,
    output logic              valid,
    output logic              changed,
    output logic              busy,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int CNT_W  = $clog2(W + 1);
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [W-1:0]      prioCode;
    logic              anyReq;
    convState_t        state;
    convState_t        nextState;
    logic              startConv;
    logic              pending;
    logic              convValid;
    logic              dispValid;
    logic [CNT_W-1:0]  shCnt;
    logic [W-1:0]      shBin;
    logic [BCD_W-1:0]  shBcd;
    logic [BCD_W-1:0]  adjBcd;
    logic [BCD_W-1:0]  dispBcd;
    logic [SCAN_W-1:0] scanCnt;
    logic [DIG_W-1:0]  digitIdx;
    logic [3:0]        curNibble;
    logic              blankDigit;
    logic [6:0]        digitSeg;

    // Later (higher) indices overwrite earlier ones, so the highest set bit wins.
    always_comb begin
        prioCode = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) prioCode = W'(i);
        end
    end

    assign anyReq = |req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code    <= '0;
            valid   <= 1'b0;
            changed <= 1'b0;
        end else if (sample) begin
            code    <= prioCode;
            valid   <= anyReq;
            changed <= ({anyReq, prioCode} != {valid, code});
        end else begin
            changed <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        startConv = 1'b0;
        case (state)
            IDLE: begin
                if (sample || pending) begin
                    nextState = SHIFT;
                    startConv = 1'b1;
                end
            end
            SHIFT: begin
                if (shCnt == CNT_W'(W - 1)) nextState = DONE;
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // A sample arriving mid-conversion is remembered once; code holds the newest value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending   <= 1'b0;
            shCnt     <= '0;
            convValid <= 1'b0;
            dispValid <= 1'b0;
        end else begin
            pending <= (state != IDLE) && (pending || sample);
            if (startConv) begin
                shCnt     <= '0;
                convValid <= sample ? anyReq : valid;
            end else if (state == SHIFT) begin
                shCnt <= shCnt + 1'b1;
            end
            if (state == DONE) dispValid <= convValid;
        end
    end

    always_comb begin
        adjBcd = shBcd;
        for (int k = 0; k < DIGITS; k++) begin
            if (adjBcd[4*k +: 4] >= 4'd5) adjBcd[4*k +: 4] = adjBcd[4*k +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (startConv) begin
            shBin <= sample ? prioCode : code;
            shBcd <= '0;
        end else if (state == SHIFT) begin
            shBin <= shBin << 1;
            shBcd <= {adjBcd[BCD_W-2:0], shBin[W-1]};
        end
        if (state == DONE) dispBcd <= shBcd;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scanCnt  <= '0;
            digitIdx <= '0;
        end else if (scanCnt == SCAN_W'(SCAN_DIV - 1)) begin
            scanCnt  <= '0;
            digitIdx <= (digitIdx == DIG_W'(DIGITS - 1)) ? '0 : digitIdx + 1'b1;
        end else begin
            scanCnt <= scanCnt + 1'b1;
        end
    end

    // A digit is blank when it and every more-significant digit are zero.
    always_comb begin
        curNibble  = 4'd0;
        blankDigit = (digitIdx != '0);
        an         = '1;
        for (int d = 0; d < DIGITS; d++) begin
            if (digitIdx == DIG_W'(d)) curNibble = dispBcd[4*d +: 4];
            if ((DIG_W'(d) >= digitIdx) && (dispBcd[4*d +: 4] != 4'd0)) blankDigit = 1'b0;
            an[d] = (digitIdx != DIG_W'(d));
        end
    end

    bcd_to_7seg u_bcdToSeg (
        .bcd(curNibble),
        .seg(digitSeg)
    );

    assign seg = !dispValid ? SEG_DASH : (blankDigit ? SEG_BLANK : digitSeg);

endmodule
